// File: rtl/multdiv_sequencer.sv
// Control sequencer for the multi-cycle multiply/divide unit: drives clr/en of the
// datapath DFF banks, counts iterations and reports completion, exception and stall.
module multdiv_sequencer #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             div_by_zero,
    output logic             reg_clr,
    output logic             reg_en,
    output logic             is_div,
    output logic [CNT_W-1:0] step,
    output logic             stall,
    output logic             data_resultRDY,
    output logic             data_exception
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    logic [1:0]       state;
    logic             div_q;
    logic             exc_q;
    logic             start;
    logic [CNT_W-1:0] last_step;

    // A start is accepted only when exactly one request is raised.
    assign start     = ctrl_MULT ^ ctrl_DIV;
    assign last_step = div_q ? DIV_LAST : MULT_LAST;

    // NOTE: reg_clr is combinational from the start pulse, so it must be gated by
    // reset_n explicitly to stay low while reset is held.
    assign reg_clr        = reset_n & start;
    assign reg_en         = (state == S_RUN);
    assign stall          = (state == S_RUN);
    assign data_resultRDY = (state == S_DONE);
    assign data_exception = (state == S_DONE) & exc_q;
    assign is_div         = div_q;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            step  <= '0;
            div_q <= 1'b0;
            exc_q <= 1'b0;
        end else if (start) begin
            div_q <= ctrl_DIV;
            step  <= '0;
            if (ctrl_DIV && div_by_zero) begin
                state <= S_DONE;
                exc_q <= 1'b1;
            end else begin
                state <= S_RUN;
                exc_q <= 1'b0;
            end
        end else begin
            case (state)
                S_RUN: begin
                    if (step == last_step) begin
                        state <= S_DONE;
                    end else begin
                        step <= step + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // Returning to IDLE clears the latched context so IDLE shows all-zero outputs.
                    state <= S_IDLE;
                    step  <= '0;
                    div_q <= 1'b0;
                    exc_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
